// File: rtl/posibus_pkg.sv
// ----------------------------------------------------------------------------
// posibus_pkg
// Shared definitions for the positive-logic I/O bus.
//   IOP1_BIT/IOP2_BIT/IOP4_BIT : bit positions of the IOP strobes on bus_iop
//   NUM_IOP                    : number of IOP strobe lines
//   DEFAULT_WIDTH              : data bus width shared with the bus-driver side
// ----------------------------------------------------------------------------
package posibus_pkg;

    localparam int IOP1_BIT      = 0;
    localparam int IOP2_BIT      = 1;
    localparam int IOP4_BIT      = 2;
    localparam int NUM_IOP       = 3;
    localparam int DEFAULT_WIDTH = 12;

endpackage : posibus_pkg

// File: rtl/posibus_receiver_bus_line_filter.sv
// ----------------------------------------------------------------------------
// bus_line_filter
// One asynchronous bus line: synchroniser chain followed by a debounce filter.
// The filtered level changes only after the synced input has disagreed with it
// for FILT consecutive cycles.
//   clk   in  : system clock
//   rst_n in  : asynchronous active-low reset
//   d     in  : raw asynchronous bus line
//   q     out : filtered level
//   rise  out : one-cycle pulse, registered together with the 0->1 change of q
// ----------------------------------------------------------------------------
module bus_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    // Counter must hold 0..FILT-1; keep at least one bit when FILT == 1.
    localparam int             CW    = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0]  C_MAX = CW'(FILT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_state;
    logic                   r_rise;
    logic [CW-1:0]          r_cnt;

    logic w_synced;
    logic w_diff;
    logic w_take;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_diff   = (w_synced != r_state);
    assign w_take   = w_diff && (r_cnt == C_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_state <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_take) begin
                r_state <= w_synced;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            // Rise is flagged in the same edge that flips the state to 1.
            r_rise <= w_take && w_synced;
        end
    end

    assign q    = r_state;
    assign rise = r_rise;

endmodule : bus_line_filter

// File: rtl/posibus_receiver.sv
// ----------------------------------------------------------------------------
// posibus_receiver
// Receiving end of the wire-OR I/O bus. Synchronises the data, IOP and INT
// lines, deglitches IOP/INT, captures the data word on any filtered IOP rise
// and presents it downstream over valid/ready.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus_data     : raw data bus (WIDTH bits)
//   bus_iop      : raw IOP1/IOP2/IOP4 strobes (bits 0/1/2)
//   bus_int      : raw interrupt request
//   out_data     : captured word
//   out_iop      : filtered IOP rises that caused the capture
//   out_valid    : holding register full
//   out_ready    : downstream accept
//   overrun      : sticky, a capture was lost while the holder was full
//   overrun_clr  : synchronous clear of overrun
//   int_req      : filtered bus_int level
// ----------------------------------------------------------------------------
module posibus_receiver
    import posibus_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   bus_data,
    input  logic [NUM_IOP-1:0] bus_iop,
    input  logic               bus_int,
    output logic [WIDTH-1:0]   out_data,
    output logic [NUM_IOP-1:0] out_iop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overrun,
    input  logic               overrun_clr,
    output logic               int_req
);

    logic [WIDTH-1:0]   r_data_sync [SYNC_STAGES];
    logic [WIDTH-1:0]   r_data;
    logic [NUM_IOP-1:0] r_iop;
    logic               r_valid;
    logic               r_overrun;

    logic [NUM_IOP-1:0] w_iop_level;
    logic [NUM_IOP-1:0] w_iop_rise;
    logic               w_int_level;
    logic               w_int_rise;
    logic               w_capture;
    logic [WIDTH-1:0]   w_data_synced;
    logic               w_unused_lines;

    genvar g;
    generate
        for (g = 0; g < NUM_IOP; g++) begin : g_iop
            bus_line_filter #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT        (FILT)
            ) u_iop_filter (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (bus_iop[g]),
                .q     (w_iop_level[g]),
                .rise  (w_iop_rise[g])
            );
        end
    endgenerate

    bus_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT        (FILT)
    ) u_int_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus_int),
        .q     (w_int_level),
        .rise  (w_int_rise)
    );

    // Only IOP rises and the INT level are consumed.
    assign w_unused_lines = ^{w_iop_level, w_int_rise};

    // Data chain has the same depth as the strobe chains, so the synced word
    // is aligned with the synced strobes.
    assign w_data_synced = r_data_sync[SYNC_STAGES-1];
    assign w_capture     = |w_iop_rise;

    // Handshake: a word transfers on any edge where out_valid && out_ready.
    // out_data/out_iop are stable while out_valid is high and not accepted.
    // A capture coinciding with an accept replaces the word without a bubble;
    // a capture while the word is held and not accepted is dropped and flagged
    // in overrun (set has priority over overrun_clr).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= '0;
            end
            r_data    <= '0;
            r_iop     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_data_sync[0] <= bus_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= r_data_sync[i-1];
            end

            if (w_capture) begin
                if (!r_valid || out_ready) begin
                    r_data  <= w_data_synced;
                    r_iop   <= w_iop_rise;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end

            if (w_capture && r_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_iop   = r_iop;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;
    assign int_req   = w_int_level;

endmodule : posibus_receiver

// File: tb/tb_posibus_receiver.sv
module tb_posibus_receiver;

    localparam int WIDTH = 12;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] bus_data;
    logic [2:0]       bus_iop;
    logic             bus_int;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_iop;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             overrun_clr;
    logic             int_req;

    int n_checks = 0;
    int n_errors = 0;

    posibus_receiver #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .FILT        (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_data    (bus_data),
        .bus_iop     (bus_iop),
        .bus_int     (bus_int),
        .out_data    (out_data),
        .out_iop     (out_iop),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .int_req     (int_req)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a strobe pattern with a data word, hold it for hi clocks, then
    // drop the strobes and let the filters settle back to low.
    task automatic pulse_iop(input logic [WIDTH-1:0] d, input logic [2:0] m, input int hi);
        @(negedge clk);
        bus_data = d;
        bus_iop  = m;
        repeat (hi) @(posedge clk);
        @(negedge clk);
        bus_iop = 3'b000;
        repeat (12) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Test 1: reset values with lines high, then one capture after release
        rst_n       = 1'b0;
        bus_data    = 12'o7777;
        bus_iop     = 3'b111;
        bus_int     = 1'b1;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        settle(3);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data",  32'(out_data),  32'd0);
        check_eq("rst_out_iop",   32'(out_iop),   32'd0);
        check_eq("rst_overrun",   32'(overrun),   32'd0);
        check_eq("rst_int_req",   32'(int_req),   32'd0);
        rst_n = 1'b1;
        settle(10);
        check_eq("t1_valid",   32'(out_valid), 32'd1);
        check_eq("t1_iop",     32'(out_iop),   32'h7);
        check_eq("t1_data",    32'(out_data),  32'o7777);
        check_eq("t1_int_req", 32'(int_req),   32'd1);
        settle(10);
        check_eq("t1_single_capture", 32'(overrun), 32'd0);
        bus_iop   = 3'b000;
        bus_int   = 1'b0;
        bus_data  = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("t1_accept", 32'(out_valid), 32'd0);
        settle(12);
        check_eq("t1_int_fall", 32'(int_req), 32'd0);

        // Test 2: latency of exactly 7 edges, then accept
        bus_data = 12'o1234;
        bus_iop  = 3'b001;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("t2_not_yet_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("t2_valid", 32'(out_valid), 32'd1);
        check_eq("t2_data",  32'(out_data),  32'o1234);
        check_eq("t2_iop",   32'(out_iop),   32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("t2_hold_data", 32'(out_data), 32'o1234);
        bus_iop   = 3'b000;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("t2_accept", 32'(out_valid), 32'd0);
        settle(12);
        check_eq("t2_no_fall_capture", 32'(out_valid), 32'd0);

        // Test 3: short glitches are ignored
        pulse_iop(12'o5555, 3'b010, 3);
        check_eq("t3_iop_glitch", 32'(out_valid), 32'd0);
        bus_int = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus_int = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("t3_int_glitch_mid", 32'(int_req), 32'd0);
        settle(8);
        check_eq("t3_int_glitch", 32'(int_req), 32'd0);

        // Test 4: overrun while the holder is full, then clear
        pulse_iop(12'o0001, 3'b001, 10);
        check_eq("t4_first_valid", 32'(out_valid), 32'd1);
        check_eq("t4_no_overrun",  32'(overrun),   32'd0);
        pulse_iop(12'o0002, 3'b100, 10);
        check_eq("t4_data_kept", 32'(out_data), 32'o0001);
        check_eq("t4_iop_kept",  32'(out_iop),  32'h1);
        check_eq("t4_overrun",   32'(overrun),  32'd1);
        overrun_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        overrun_clr = 1'b0;
        check_eq("t4_overrun_clr", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("t4_accept", 32'(out_valid), 32'd0);

        // Test 5: capture on the same edge as an accept
        bus_data  = 12'o1111;
        bus_iop   = 3'b001;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_iop = 3'b011;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus_data = 12'o2222;
        @(posedge clk);
        @(negedge clk);
        check_eq("t5_pre_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("t5_first_valid", 32'(out_valid), 32'd1);
        check_eq("t5_first_data",  32'(out_data),  32'o1111);
        check_eq("t5_first_iop",   32'(out_iop),   32'h1);
        @(posedge clk);
        @(negedge clk);
        check_eq("t5_second_valid",   32'(out_valid), 32'd1);
        check_eq("t5_second_data",    32'(out_data),  32'o2222);
        check_eq("t5_second_iop",     32'(out_iop),   32'h2);
        check_eq("t5_second_overrun", 32'(overrun),   32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("t5_drain", 32'(out_valid), 32'd0);
        bus_iop   = 3'b000;
        out_ready = 1'b0;
        settle(12);

        // Test 6: async reset mid-hold and mid-filter
        bus_int = 1'b1;
        pulse_iop(12'o4321, 3'b001, 10);
        check_eq("t6_held_valid", 32'(out_valid), 32'd1);
        check_eq("t6_int_req",    32'(int_req),   32'd1);
        bus_iop = 3'b100;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
        check_eq("t6_rst_data",  32'(out_data),  32'd0);
        check_eq("t6_rst_iop",   32'(out_iop),   32'd0);
        check_eq("t6_rst_int",   32'(int_req),   32'd0);
        bus_iop  = 3'b000;
        bus_int  = 1'b0;
        bus_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        settle(20);
        check_eq("t6_no_spurious_valid",   32'(out_valid), 32'd0);
        check_eq("t6_no_spurious_overrun", 32'(overrun),   32'd0);
        check_eq("t6_no_spurious_int",     32'(int_req),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_posibus_receiver
